mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Sits directly upstream of the word-addressed data memory in the MEM stage. Takes EX/MEM load/store requests with byte addresses, converts them into word-indexed memory accesses, and sign- or zero-extends sub-word loads. Sub-word stores are done as read-modify-write. Holds the pipeline with stall_o while a multi-cycle access is in flight.

Parameters:
MEM_LATENCY, 1, cycles the memory needs read/write held per access (>=1)
WORD_ADDR_W, 5, width of the word index driven to memory (32 words)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
req_valid_i  in  1  EX/MEM slot holds a memory op; held stable while stall_o=1
req_read_i  in  1  load
req_write_i  in  1  store
req_size_i  in  2  00 byte, 01 half, 10 word; 11 is illegal
req_unsigned_i  in  1  zero-extend load (lbu/lhu)
req_addr_i  in  32  byte address (ALU result)
req_wdata_i  in  32  store data, right-aligned
stall_o  out  1  freeze PC/IF/ID/EX and EX/MEM
resp_valid_o  out  1  one-cycle completion pulse
resp_rdata_o  out  32  extended load data, valid with resp_valid_o
misalign_o  out  1  illegal request, pulses with resp_valid_o
mem_read_o  out  1  memory read enable
mem_write_o  out  1  memory write enable
mem_addr_o  out  32  word index, zero-extended: req_addr[WORD_ADDR_W+1:2]
mem_wdata_o  out  32  word to write
mem_rdata_i  in  32  memory read word

Behaviour:
- Reset (async, active-high) sets:
  - state=IDLE and counter=0.
  - resp_rdata_o=0, resp_valid_o=0 and misalign_o=0.
  - mem_read_o=0, mem_write_o=0, mem_addr_o=0 and mem_wdata_o=0.
  - stall_o=0.
- Reset mid-access abandons the access. Memory enables drop immediately, and a partial RMW write is never issued.
- States are IDLE, RD, WR, RMW_RD, RMW_WR and DONE.
- IDLE:
  - A request is accepted when req_valid_i and (req_read_i or req_write_i). Its address, size, unsigned flag and data are latched on that edge.
  - stall_o is combinationally 1 in the accept cycle.
  - Neither read nor write set: no request, stall_o=0.
- Illegal request goes IDLE->DONE with no memory enable asserted, resp_rdata_o=0 and misalign_o=1. A request is illegal if any of these hold:
  - read and write both set;
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0.
- Legal request dispatch:
  - Load goes to RD.
  - Word store goes to WR.
  - Byte/half store goes to RMW_RD.
- RD, WR, RMW_RD and RMW_WR each last exactly MEM_LATENCY cycles, tracked by a down-counter. The corresponding mem enable is 1 and mem_addr_o is stable for the whole state.
- Last cycle of RD: mem_rdata_i is extended and registered into resp_rdata_o, then go to DONE.
- Last cycle of RMW_RD:
  - mem_rdata_i is merged with the store data and registered as mem_wdata_o, then go to RMW_WR.
  - Byte: lane addr[1:0] replaced by wdata[7:0].
  - Half: lane addr[1] replaced by wdata[15:0].
- WR: mem_wdata_o=req_wdata.
- stall_o=1 in every state except IDLE (no accept) and DONE.
- DONE:
  - resp_valid_o=1 and stall_o=0, so the pipeline advances at this edge.
  - Next state is always IDLE.
  - A request visible on the inputs in DONE is the completed one and is not re-accepted.
- Lanes are little-endian: byte k = bits[8k+7:8k], half h = bits[16h+15:16h].
- Loads are sign-extended unless req_unsigned_i=1. Word loads pass through unchanged.
- Latency from accept cycle (cycle 0) to resp_valid_o:
  - Load or word store: MEM_LATENCY+1 cycles.
  - Sub-word store: 2*MEM_LATENCY+1 cycles.
  - Illegal request: 1 cycle.
- resp_rdata_o holds its value until the next completed load or illegal response. Store completion leaves it unchanged.

Test Plan:
1. MEM_LATENCY=1, sw addr 0x10 data 0xDEADBEEF -> mem_write_o=1 and mem_addr_o=4 for 1 cycle, resp_valid_o at cycle 2. Then lw 0x10 -> resp_rdata_o=0xDEADBEEF, stall_o high 2 cycles.
2. Word 4 = 0x80FF1234:
   - lb 0x13 -> 0xFFFFFF80.
   - lbu 0x13 -> 0x00000080.
   - lh 0x12 -> 0xFFFF80FF.
   - lhu 0x10 -> 0x00001234.
3. Word 4 = 0x11223344, sb 0x11 data 0x000000AA -> mem_read_o 1 cycle, then mem_write_o 1 cycle with mem_wdata_o=0x1122AA44. resp_valid_o at cycle 3, stall_o high cycles 0-2.
4. lw 0x06 -> misalign_o=1, resp_valid_o=1 and resp_rdata_o=0 at cycle 1, no mem enable ever asserted. sh 0x11 -> same behaviour.
5. MEM_LATENCY=3:
   - lw -> mem_read_o held 3 cycles, resp_valid_o at cycle 4.
   - sh 0x12: rst_i pulsed during RMW_WR -> mem_write_o=0 same cycle, stall_o=0 and state IDLE, memory word unchanged.
6. Back-to-back lw 0x0 then sw 0x4, second request presented the cycle after DONE -> exactly one access each, no duplicate mem_read_o, and each resp_valid_o is a single-cycle pulse.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: converts byte-addressed EX/MEM loads and stores into
// word-indexed memory accesses. Sub-word loads are extended, and sub-word
// stores are done as read-modify-write. The pipeline is held while an access
// is in flight.
module mem_access_unit #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned WORD_ADDR_W = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_read_i,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        stall_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        misalign_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WR     = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Latched request fields
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [15:0] wdata_q, wdata_d;

  // Registered outputs
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        misalign_q, misalign_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        accept_c;
  logic        illegal_c;
  logic        last_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] load_ext_c;
  logic [31:0] merge_c;
  logic        unused_addr;

  // Address bits above the word index never reach the memory
  assign unused_addr = ^req_addr_i[31:WORD_ADDR_W+2];

  // Request qualification
  assign accept_c  = (state_q == S_IDLE) && req_valid_i && (req_read_i || req_write_i);
  assign illegal_c = (req_read_i && req_write_i) ||
                     (req_size_i == 2'b11) ||
                     ((req_size_i == SZ_HALF) && req_addr_i[0]) ||
                     ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
  assign last_c    = (cnt_q == '0);

  // Little-endian lane extraction from the returned memory word
  assign byte_c = mem_rdata_i[{addr_lo_q, 3'b000} +: 8];
  assign half_c = mem_rdata_i[{addr_lo_q[1], 4'b0000} +: 16];

  // Sign/zero extension of load data
  always_comb begin
    load_ext_c = mem_rdata_i;
    case (size_q)
      SZ_BYTE: load_ext_c = uns_q ? {24'h000000, byte_c} : {{24{byte_c[7]}}, byte_c};
      SZ_HALF: load_ext_c = uns_q ? {16'h0000, half_c}   : {{16{half_c[15]}}, half_c};
      default: load_ext_c = mem_rdata_i;
    endcase
  end

  // Merge sub-word store data into the word read back for RMW
  always_comb begin
    merge_c = mem_rdata_i;
    if (size_q == SZ_BYTE) begin
      merge_c[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merge_c[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and per-state down-counter
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (illegal_c)                 state_d = S_DONE;
          else if (req_read_i)           state_d = S_RD;
          else if (req_size_i == SZ_WORD) state_d = S_WR;
          else                           state_d = S_RMW_RD;
        end
      end
      S_RD:     if (last_c) state_d = S_DONE;
      S_WR:     if (last_c) state_d = S_DONE;
      S_RMW_RD: if (last_c) state_d = S_RMW_WR;
      S_RMW_WR: if (last_c) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (state_d != state_q)  cnt_d = CNT_LOAD;
    else if (!last_c)        cnt_d = cnt_q - CNT_W'(1);
    else                     cnt_d = cnt_q;
  end

  // Output and datapath next values
  always_comb begin
    addr_lo_d    = addr_lo_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = (state_d == S_DONE);
    misalign_d   = 1'b0;
    mem_read_d   = (state_d == S_RD) || (state_d == S_RMW_RD);
    mem_write_d  = (state_d == S_WR) || (state_d == S_RMW_WR);

    if (accept_c) begin
      addr_lo_d  = req_addr_i[1:0];
      size_d     = req_size_i;
      uns_d      = req_unsigned_i;
      wdata_d    = req_wdata_i[15:0];
      mem_addr_d = 32'(req_addr_i[WORD_ADDR_W+1:2]);
      if (illegal_c) begin
        resp_rdata_d = 32'h0000_0000;
        misalign_d   = 1'b1;
      end else if (req_write_i && (req_size_i == SZ_WORD)) begin
        mem_wdata_d = req_wdata_i;
      end
    end

    if ((state_q == S_RD) && last_c)     resp_rdata_d = load_ext_c;
    if ((state_q == S_RMW_RD) && last_c) mem_wdata_d  = merge_c;
  end

  // Output and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_lo_q    <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      addr_lo_q    <= addr_lo_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_valid_q <= resp_valid_d;
      misalign_q   <= misalign_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Stall is combinational so the accept cycle already freezes the pipeline
  assign stall_o = (state_q == S_IDLE) ? accept_c : (state_q != S_DONE);

  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign misalign_o   = misalign_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule
